// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and constants for the two-port BRAM arbiter.
// Holds the port index type, port count, read latency and pointer reset value.
package bram_arb_pkg;

    typedef logic [0:0] port_id_t;

    localparam int NUM_PORTS  = 2;
    localparam int RD_LATENCY = 2;

    // Pointer starts at port 1 so port 0 wins the first tie.
    localparam port_id_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/bram_1rw.sv
// bram_1rw: single-port block RAM with a registered read output.
// Ports: clka clock; ena enable; wea write enable; addra address;
//        dina write data; douta read data, one cycle after a read, held on writes.
module bram_1rw #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int MEMSIZE    = 1
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta
);

    logic [DATA_WIDTH-1:0] mem [0:MEMSIZE-1];

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
            end else begin
                douta <= mem[addra];
            end
        end
    end

endmodule

// File: rtl/bram_1rw_arb.sv
// bram_1rw_arb: shares one bram_1rw between two valid/ready requesters,
// one access per cycle, with a one-entry read response register per port.
// Ports: clka clock; rsta sync active-high reset;
//        pN_req_valid/ready/we/addr/wdata request channel of port N;
//        pN_rsp_valid/ready/rdata read response channel of port N.
// Build option: define BRAM_ARB_RR_EN for round-robin, else port 0 has priority.
module bram_1rw_arb
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int MEMSIZE    = 1
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    input  logic                  p0_rsp_ready,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    input  logic                  p1_rsp_ready,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata
);

    logic [NUM_PORTS-1:0]  req_v;
    logic [NUM_PORTS-1:0]  req_we;
    logic [NUM_PORTS-1:0]  rsp_rdy;
    logic [ADDR_WIDTH-1:0] req_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] req_wdata [NUM_PORTS];

    logic [NUM_PORTS-1:0]  elig;
    logic [NUM_PORTS-1:0]  gnt;
    port_id_t              gid;

    logic [NUM_PORTS-1:0]  inflight_q, inflight_d;
    logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rsp_data_d [NUM_PORTS];
    logic                  rst_q;

    logic                  ena;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic [DATA_WIDTH-1:0] douta;

    assign req_v        = {p1_req_valid, p0_req_valid};
    assign req_we       = {p1_req_we, p0_req_we};
    assign rsp_rdy      = {p1_rsp_ready, p0_rsp_ready};
    assign req_addr[0]  = p0_req_addr;
    assign req_addr[1]  = p1_req_addr;
    assign req_wdata[0] = p0_req_wdata;
    assign req_wdata[1] = p1_req_wdata;

    // A read needs a free response slot by the time its data lands.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = req_v[i] &&
                      (req_we[i] ||
                       (!inflight_q[i] && (!rsp_valid_q[i] || rsp_rdy[i])));
        end
    end

`ifdef BRAM_ARB_RR_EN
    port_id_t last_grant_q;
`endif

    // Nothing is granted in reset or in the cycle right after it.
    always_comb begin
        gnt = '0;
`ifdef BRAM_ARB_RR_EN
        if (&elig) begin
            gid = ~last_grant_q;
        end else begin
            gid = elig[1];
        end
`else
        gid = ~elig[0];
`endif
        if (!rsta && !rst_q) begin
            gnt[gid] = elig[gid];
        end
    end

    assign ena   = |gnt;
    assign wea   = req_we[gid];
    assign addra = req_addr[gid];
    assign dina  = req_wdata[gid];

    // Capture of returning data wins over a same-cycle dequeue.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            inflight_d[i]  = gnt[i] & ~req_we[i];
            rsp_valid_d[i] = rsp_valid_q[i];
            rsp_data_d[i]  = rsp_data_q[i];
            if (inflight_q[i]) begin
                rsp_valid_d[i] = 1'b1;
                rsp_data_d[i]  = douta;
            end else if (rsp_valid_q[i] && rsp_rdy[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            inflight_q  <= '0;
            rsp_valid_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rsp_data_q[i] <= '0;
            end
        end else begin
            inflight_q  <= inflight_d;
            rsp_valid_q <= rsp_valid_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rsp_data_q[i] <= rsp_data_d[i];
            end
        end
    end

    always_ff @(posedge clka) begin
        rst_q <= rsta;
    end

`ifdef BRAM_ARB_RR_EN
    always_ff @(posedge clka) begin
        if (rsta) begin
            last_grant_q <= LAST_GRANT_RST;
        end else if (|gnt) begin
            last_grant_q <= gid;
        end
    end
`endif

    bram_1rw #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEMSIZE    (MEMSIZE)
    ) u_bram (
        .clka  (clka),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta)
    );

    assign p0_req_ready = gnt[0];
    assign p1_req_ready = gnt[1];
    assign p0_rsp_valid = rsp_valid_q[0];
    assign p1_rsp_valid = rsp_valid_q[1];
    assign p0_rsp_rdata = rsp_data_q[0];
    assign p1_rsp_rdata = rsp_data_q[1];

endmodule

// File: tb/tb_bram_1rw_arb.sv
// tb_bram_1rw_arb: directed scenarios plus randomized traffic against
// a behavioural model of the two-port arbiter.
module tb_bram_1rw_arb;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      vld, we, rrdy;
    logic [1:0][3:0] addr;
    logic [1:0][7:0] wd;
    logic [1:0]      rdy, rv;
    logic [1:0][7:0] rd;

    int n_pass = 0;
    int n_chk  = 0;

    logic [7:0] mem_m [16];

    always #5 clk = ~clk;

    bram_1rw_arb #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8),
        .MEMSIZE    (16)
    ) dut (
        .clka         (clk),
        .rsta         (rst),
        .p0_req_valid (vld[0]),
        .p0_req_ready (rdy[0]),
        .p0_req_we    (we[0]),
        .p0_req_addr  (addr[0]),
        .p0_req_wdata (wd[0]),
        .p0_rsp_valid (rv[0]),
        .p0_rsp_ready (rrdy[0]),
        .p0_rsp_rdata (rd[0]),
        .p1_req_valid (vld[1]),
        .p1_req_ready (rdy[1]),
        .p1_req_we    (we[1]),
        .p1_req_addr  (addr[1]),
        .p1_req_wdata (wd[1]),
        .p1_rsp_valid (rv[1]),
        .p1_rsp_ready (rrdy[1]),
        .p1_rsp_rdata (rd[1])
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic idle;
        vld = '0;
        we  = '0;
    endtask

    task automatic do_write(input int p, input logic [3:0] a, input logic [7:0] d);
        bit ok = 0;
        vld[p] = 1'b1; we[p] = 1'b1; addr[p] = a; wd[p] = d;
        for (int k = 0; k < 10 && !ok; k++) begin
            settle;
            if (rdy[p]) ok = 1;
            step;
        end
        vld[p] = 1'b0; we[p] = 1'b0;
        n_chk++;
        if (ok) begin
            n_pass++;
            mem_m[a] = d;
        end else
            $display("FAIL wr_timeout port=%0d addr=%0d got no ready, need ready", p, a);
    endtask

    task automatic do_read(input int p, input logic [3:0] a, output logic [7:0] d);
        bit acc = 0;
        bit got = 0;
        d = 'x;
        vld[p] = 1'b1; we[p] = 1'b0; addr[p] = a; rrdy[p] = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            settle;
            if (rdy[p]) acc = 1;
            step;
        end
        vld[p] = 1'b0;
        for (int k = 0; k < 10 && acc && !got; k++) begin
            settle;
            if (rv[p]) begin
                got = 1;
                d = rd[p];
            end else step;
        end
        if (got) begin
            rrdy[p] = 1'b1;
            step;
            rrdy[p] = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; vld = 2'b11; we = '0; rrdy = 2'b11;
        addr[0] = 4'd1; addr[1] = 4'd2; wd = '0;
        step; step; settle;
        n_chk++;
        if ({rdy, rv, rd} !== 20'h0)
            $display("FAIL rst_state rdy=%b rv=%b rd=%h need all zero", rdy, rv, rd);
        else n_pass++;
        step;
        rst = 1'b0;
        settle;
        n_chk++;
        if (rdy !== 2'b00)
            $display("FAIL rst_after_ready rdy=%b need 00", rdy);
        else n_pass++;
        idle; rrdy = '0;
        step;
    endtask

    task automatic test_preload;
        for (int a = 0; a < 16; a++)
            do_write(a % 2, 4'(a), 8'($urandom));
    endtask

    task automatic test_write_read;
        idle;
        vld[0] = 1; we[0] = 1; addr[0] = 4'd3; wd[0] = 8'hA5;
        settle;
        n_chk++;
        if (rdy[0] !== 1'b1) $display("FAIL wr_ready got=%b need 1", rdy[0]);
        else n_pass++;
        step;
        mem_m[3] = 8'hA5;
        we[0] = 0;
        settle;
        n_chk++;
        if (rdy[0] !== 1'b1) $display("FAIL rd_ready got=%b need 1", rdy[0]);
        else n_pass++;
        step;
        idle;
        settle;
        n_chk++;
        if (rv[0] !== 1'b0) $display("FAIL rd_early got=%b need 0", rv[0]);
        else n_pass++;
        step;
        settle;
        n_chk++;
        if ({rv, rd[0]} !== {2'b01, 8'hA5})
            $display("FAIL rd_data rv=%b rd0=%h need rv=01 rd0=a5", rv, rd[0]);
        else n_pass++;
        rrdy[0] = 1;
        step;
        rrdy[0] = 0;
        settle;
        n_chk++;
        if (rv[0] !== 1'b0) $display("FAIL rd_dequeue got=%b need 0", rv[0]);
        else n_pass++;
        step;
    endtask

    // Either policy yields p0,p1,p0,p1 here: each port blocks itself while in flight.
    task automatic test_simul_reads;
        int exp_g [4] = '{0, 1, 0, 1};
        int g, n0, n1;
        n0 = 0; n1 = 0;
        do_write(0, 4'd1, 8'($urandom));
        do_write(1, 4'd2, 8'($urandom));
        rrdy = 2'b11; vld = 2'b11; we = '0;
        addr[0] = 4'd1; addr[1] = 4'd2;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) vld = '0;
            settle;
            if (k < 4) begin
                g = (rdy == 2'b01) ? 0 : (rdy == 2'b10) ? 1 : 2;
                n_chk++;
                if (g !== exp_g[k])
                    $display("FAIL simul_grant cyc=%0d got=%0d need=%0d", k, g, exp_g[k]);
                else n_pass++;
            end
            if (rv[0]) begin
                n0++;
                n_chk++;
                if (rd[0] !== mem_m[1])
                    $display("FAIL simul_p0_data got=%h need=%h", rd[0], mem_m[1]);
                else n_pass++;
            end
            if (rv[1]) begin
                n1++;
                n_chk++;
                if (rd[1] !== mem_m[2])
                    $display("FAIL simul_p1_data got=%h need=%h", rd[1], mem_m[2]);
                else n_pass++;
            end
            step;
        end
        n_chk++;
        if (n0 != 2 || n1 != 2)
            $display("FAIL simul_count got=%0d,%0d need=2,2", n0, n1);
        else n_pass++;
        rrdy = '0;
    endtask

    task automatic test_backpressure;
        logic [7:0] wv, d;
        bit er1;
        wv = 8'($urandom);
        rrdy = 2'b01;
        for (int c = 0; c < 10; c++) begin
            idle;
            addr[1] = 4'd6;
            vld[1] = 1;
            if (c == 0) addr[1] = 4'd5;
            if (c == 3) begin
                we[1] = 1; addr[1] = 4'd9; wd[1] = wv;
            end
            if (c == 4) begin
                vld[0] = 1; addr[0] = 4'd4;
            end
            settle;
            er1 = (c == 0 || c == 3);
            n_chk++;
            if (rdy[1] !== er1)
                $display("FAIL bp_p1_ready cyc=%0d got=%b need=%b", c, rdy[1], er1);
            else n_pass++;
            if (c == 4) begin
                n_chk++;
                if (rdy[0] !== 1'b1) $display("FAIL bp_p0_ready got=%b need 1", rdy[0]);
                else n_pass++;
            end
            if (c >= 2) begin
                n_chk++;
                if ({rv[1], rd[1]} !== {1'b1, mem_m[5]})
                    $display("FAIL bp_hold cyc=%0d rv=%b rd=%h need 1 %h", c, rv[1], rd[1], mem_m[5]);
                else n_pass++;
            end
            if (c == 6) begin
                n_chk++;
                if ({rv[0], rd[0]} !== {1'b1, mem_m[4]})
                    $display("FAIL bp_p0_rsp rv=%b rd=%h need 1 %h", rv[0], rd[0], mem_m[4]);
                else n_pass++;
            end
            step;
            if (c == 3) mem_m[9] = wv;
        end
        idle;
        rrdy = 2'b11;
        step;
        settle;
        n_chk++;
        if (rv !== 2'b00) $display("FAIL bp_release rv=%b need 00", rv);
        else n_pass++;
        rrdy = '0;
        step;
        do_read(0, 4'd9, d);
        n_chk++;
        if (d !== wv) $display("FAIL bp_p1_write got=%h need=%h", d, wv);
        else n_pass++;
    endtask

    task automatic test_capture_dequeue;
        logic [7:0] got [$];
        int idx;
        bit acc;
        do_write(0, 4'd0, 8'h11);
        do_write(0, 4'd1, 8'h22);
        rrdy[0] = 1;
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            vld[0] = (idx < 2);
            we[0]  = 0;
            addr[0] = 4'(idx);
            settle;
            if (rv[0]) got.push_back(rd[0]);
            acc = rdy[0] && vld[0];
            step;
            if (acc) idx++;
        end
        idle;
        rrdy = '0;
        n_chk++;
        if (got.size() != 2 || got[0] !== 8'h11 || got[1] !== 8'h22)
            $display("FAIL cap_deq got=%p need '{11,22}", got);
        else n_pass++;
    endtask

    task automatic test_write_pending;
        logic [7:0] d;
        do_write(0, 4'd7, 8'h5A);
        rrdy = '0;
        idle;
        vld[0] = 1; addr[0] = 4'd7;
        settle;
        n_chk++;
        if (rdy[0] !== 1'b1) $display("FAIL wp_rd_ready got=%b need 1", rdy[0]);
        else n_pass++;
        step;
        idle;
        vld[1] = 1; we[1] = 1; addr[1] = 4'd7; wd[1] = 8'h3C;
        settle;
        n_chk++;
        if (rdy[1] !== 1'b1) $display("FAIL wp_wr_ready got=%b need 1", rdy[1]);
        else n_pass++;
        step;
        mem_m[7] = 8'h3C;
        idle;
        settle;
        n_chk++;
        if ({rv[0], rd[0]} !== {1'b1, 8'h5A})
            $display("FAIL wp_old rv=%b rd=%h need 1 5a", rv[0], rd[0]);
        else n_pass++;
        rrdy[0] = 1;
        step;
        rrdy[0] = 0;
        do_read(1, 4'd7, d);
        n_chk++;
        if (d !== 8'h3C) $display("FAIL wp_new got=%h need=3c", d);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read;
        logic [7:0] d;
        do_write(1, 4'd8, 8'($urandom));
        rrdy = '0;
        idle;
        vld[0] = 1; addr[0] = 4'd8;
        settle;
        n_chk++;
        if (rdy[0] !== 1'b1) $display("FAIL rmr_ready got=%b need 1", rdy[0]);
        else n_pass++;
        step;
        idle;
        rst = 1;
        step;
        rst = 0;
        for (int k = 0; k < 5; k++) begin
            settle;
            n_chk++;
            if (rv !== 2'b00) $display("FAIL rmr_no_rsp cyc=%0d rv=%b need 00", k, rv);
            else n_pass++;
            step;
        end
        do_read(0, 4'd8, d);
        n_chk++;
        if (d !== mem_m[8]) $display("FAIL rmr_keep got=%h need=%h", d, mem_m[8]);
        else n_pass++;
    endtask

    // Model: per port an outstanding-read flag with the data it will return,
    // and an optional held response; memory as a plain array.
    task automatic test_random;
        bit         m_infl [2];
        logic [7:0] m_pend [2];
        bit         m_rv   [2];
        logic [7:0] m_rd   [2];
        bit         m_last;
        bit         e [2];
        int         g;
        logic [1:0] exp_rdy;

        rst = 1; idle; rrdy = '0;
        step;
        rst = 0;
        step;
        m_infl = '{0, 0}; m_rv = '{0, 0}; m_last = 1;

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                vld[i]  = ($urandom_range(9, 0) < 7);
                we[i]   = ($urandom_range(2, 0) == 0);
                addr[i] = 4'($urandom_range(15, 0));
                wd[i]   = 8'($urandom);
                rrdy[i] = $urandom_range(1, 0);
            end
            settle;
            for (int i = 0; i < 2; i++)
                e[i] = vld[i] && (we[i] || (!m_infl[i] && (!m_rv[i] || rrdy[i])));
            g = -1;
            if (e[0] && e[1]) begin
`ifdef BRAM_ARB_RR_EN
                g = m_last ? 0 : 1;
`else
                g = 0;
`endif
            end else if (e[0]) g = 0;
            else if (e[1]) g = 1;
            exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
            n_chk++;
            if (rdy !== exp_rdy)
                $display("FAIL rnd_grant cyc=%0d got=%b need=%b", n, rdy, exp_rdy);
            else n_pass++;
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (rv[i] !== m_rv[i] || (m_rv[i] && rd[i] !== m_rd[i]))
                    $display("FAIL rnd_rsp cyc=%0d port=%0d rv=%b rd=%h need %b %h",
                             n, i, rv[i], rd[i], m_rv[i], m_rd[i]);
                else n_pass++;
            end
            for (int i = 0; i < 2; i++) begin
                if (m_infl[i]) begin
                    m_rv[i] = 1;
                    m_rd[i] = m_pend[i];
                end else if (m_rv[i] && rrdy[i]) m_rv[i] = 0;
                m_infl[i] = 0;
            end
            if (g >= 0) begin
                if (we[g]) mem_m[addr[g]] = wd[g];
                else begin
                    m_infl[g] = 1;
                    m_pend[g] = mem_m[addr[g]];
                end
                m_last = g[0];
            end
            step;
        end
        idle;
        rrdy = 2'b11;
        step; step; step;
        rrdy = '0;
    endtask

    initial begin
        rst = 1; vld = '0; we = '0; rrdy = '0; addr = '0; wd = '0;
        test_reset;
        test_preload;
        test_write_read;
        test_simul_reads;
        test_backpressure;
        test_capture_dequeue;
        test_write_pending;
        test_reset_mid_read;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, need finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/bram_1rw_arb.md
# bram_1rw_arb

Two-port arbiter and sequencer for the single-port block RAM macro `bram_1rw`. It lets two independent requesters, port 0 and port 1 (for example instruction fetch and data load/store), share one 1RW BRAM. Each requester has a valid/ready request channel and a valid/ready read-response channel. The block issues at most one BRAM access per cycle and buffers one read response per port, so a stalled consumer never loses data.

## Interface
- `ADDR_WIDTH`, default 1: BRAM address width.
- `DATA_WIDTH`, default 1: word width.
- `MEMSIZE`, default 1: number of words. Must satisfy MEMSIZE ≤ 2^ADDR_WIDTH.

Ports:
- `clka` in 1: the single clock. Everything is on its rising edge.
- `rsta` in 1: reset. Synchronous and active-high.
- `p0_req_valid`, `p1_req_valid` in 1: a request is present on that port.
- `p0_req_ready`, `p1_req_ready` out 1: the request is accepted this cycle.
- `p0_req_we`, `p1_req_we` in 1: 1 = write, 0 = read.
- `p0_req_addr`, `p1_req_addr` in ADDR_WIDTH: word address.
- `p0_req_wdata`, `p1_req_wdata` in DATA_WIDTH: write data.
- `p0_rsp_valid`, `p1_rsp_valid` out 1: read data is available.
- `p0_rsp_ready`, `p1_rsp_ready` in 1: the consumer takes the response.
- `p0_rsp_rdata`, `p1_rsp_rdata` out DATA_WIDTH: read data, held stable while `rsp_valid` is high.

## Operation
- **Per-port state:**
  - `inflight_i`: a read has been issued to the BRAM and its data is not yet captured.
  - `rsp_valid_i` / `rsp_data_i`: the one-entry response register.
- **Eligibility:** port i is eligible when `req_valid_i` is high and either:
  - the request is a write, or
  - `!inflight_i && (!rsp_valid_i || rsp_ready_i)`.
- **Grant:**
  - At most one eligible port is granted per cycle.
  - `req_ready_i` is high only for the granted port. It is combinational from the valids, `rsp_ready` and internal state.
- **BRAM drive on grant:**
  - `ena`=1, `wea`=`req_we`, `addra`/`dina` taken from the granted port.
  - No grant means `ena`=0.
- **Read path:**
  - Issue in cycle T sets `inflight_i` at the next edge.
  - In cycle T+1, `douta` is loaded into `rsp_data_i`, `rsp_valid_i` is set and `inflight_i` is cleared.
- **Writes:** no response. The BRAM output register keeps its previous value during a write.
- **Response dequeue:** on `rsp_valid_i && rsp_ready_i`. If a capture for the same port happens in the same cycle, the capture wins and `rsp_valid_i` stays 1 with the new data.
- **Arbitration pointer:** `last_grant` is updated on every grant and is used only when `BRAM_ARB_RR_EN` is defined.
- **Boundary cases:**
  - Both ports request the same address in one cycle: they are serialised. The write-vs-read order follows the grant order; there is no forwarding.
  - An address ≥ MEMSIZE is passed to the BRAM unchanged; the result is undefined and this is the caller's responsibility.
  - Reset mid-operation: all in-flight reads and buffered responses are discarded. BRAM contents are not cleared.

## Timing
- Values while `rsta` is high and in the cycle after it: `req_ready*`=0, `rsp_valid*`=0, `rsp_rdata*`=0, `inflight*`=0, `last_grant`=1 (port 0 is favoured first).
- Read latency from request handshake to `rsp_valid` is 2 cycles: issue at T, BRAM data at T+1, registered response visible at T+2.
- **Per-port read throughput:** at most one read every 2 cycles, because the port is blocked while `inflight_i` is set.
- **Aggregate throughput:** two interleaved ports reach 1 access per cycle.
- A write is accepted in the handshake cycle and takes effect in the BRAM at that edge. A read issued in the following cycle returns the new data.
- `rsp_valid_i` stays high until it is dequeued. `rsp_rdata_i` is stable during that time.

## Configuration
- `BRAM_ARB_RR_EN` defined: round-robin. When both ports are eligible, the port not equal to `last_grant` wins.
- `BRAM_ARB_RR_EN` undefined: fixed priority. Port 0 always wins when it is eligible, and `last_grant` logic is compiled out.

## Structure
- Shared package `bram_arb_pkg` holds:
  - port index type `port_id_t` (1 bit),
  - constants `NUM_PORTS`=2 and `RD_LATENCY`=2,
  - the reset value of `last_grant`.
- One sub-module: the existing `bram_1rw`, instantiated with ADDR_WIDTH, DATA_WIDTH and MEMSIZE passed through.
- Arbitration, eligibility and response registers are inline; there are no further sub-modules.

## Test plan
- **Single-port write then read:** p0 writes addr 3 = 0xA5 at T, then p0 reads addr 3 at T+1 → `p0_rsp_valid` at T+3 with data 0xA5, and p1 sees no response.
- **Simultaneous reads, RR build:** both ports hold valid reads for 4 cycles (p0 addr 1, p1 addr 2) → grants go p0, p1, p0, p1. Responses carry the data of addr 1 and addr 2 respectively. Without `BRAM_ARB_RR_EN`, p0 wins whenever it is eligible.
- **Response backpressure:** p1 reads addr 5 with `p1_rsp_ready`=0 for 10 cycles → `p1_rsp_valid` is held and the data stays stable. `p1_req_ready` stays 0 for further reads, while p1 writes and p0 traffic still proceed.
- **Capture and dequeue in one cycle:** p0 `rsp_ready`=1 held high, back-to-back reads of addrs 0 and 1 → each response is delivered exactly once, in order, with none dropped or duplicated.
- **Write during pending response:** p0 read of addr 7 is outstanding, then p1 writes addr 7 = 0x3C → the p0 response returns the old value, and a later read returns 0x3C.
- **Reset mid-read:** assert `rsta` in the cycle after a read is issued → `rsp_valid` never rises. After reset, a read of the previously written address returns the value written before reset.
